// File: rtl/bcd2bin.sv
// Sequential signed-BCD to two's-complement converter: one digit per clock,
// start/busy/done handshake, and an error flag for malformed or out-of-range input.
module bcd2bin #(
  parameter int width  = 6,
  parameter int digits = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*digits-1:0]   bcd,
  input  logic [3:0]            bcd_sgn,
  output logic                  busy,
  output logic                  done,
  output logic [width-1:0]      bin,
  output logic                  err
);

  localparam int acc_w = width + 4;
  localparam int cnt_w = $clog2(digits) + 1;
  localparam logic [acc_w-1:0] half    = {{(acc_w-1){1'b0}}, 1'b1} << (width - 1);
  localparam logic [acc_w-1:0] half_m1 = half - {{(acc_w-1){1'b0}}, 1'b1};
  localparam logic [cnt_w-1:0] last    = cnt_w'(digits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [4*digits-1:0]   digs, digs_n;
  logic [3:0]            sgn, sgn_n;
  logic [acc_w-1:0]      acc, acc_n;
  logic [cnt_w-1:0]      cnt, cnt_n;
  logic                  ovf, ovf_n;
  logic                  bad, bad_n;
  logic                  busy_n, done_n, err_n;
  logic [width-1:0]      bin_n;

  logic [3:0]            digit;
  logic [acc_w-1:0]      step;
  logic                  is_plus, is_minus, mag_bad, fault;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  // Datapath helpers: the MS latched digit is always at the top of digs.
  always_comb begin
    digit    = digs[4*digits-1 -: 4];
    step     = (acc << 3) + (acc << 1) + {{width{1'b0}}, digit};
    is_plus  = (sgn == 4'hF);
    is_minus = (sgn == 4'hA);
    if (is_minus) begin
      mag_bad = (acc > half);
    end else begin
      mag_bad = (acc > half_m1);
    end
    fault = bad | ovf | ~(is_plus | is_minus) | mag_bad;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    digs_n  = digs;
    sgn_n   = sgn;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    bad_n   = bad;
    busy_n  = busy;
    done_n  = 1'b0;
    bin_n   = bin;
    err_n   = err;
    case (state)
      IDLE: begin
        if (start) begin
          digs_n  = bcd;
          sgn_n   = bcd_sgn;
          acc_n   = {acc_w{1'b0}};
          cnt_n   = {cnt_w{1'b0}};
          ovf_n   = 1'b0;
          bad_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = CONV;
        end else begin
          state_n = IDLE;
        end
      end
      CONV: begin
        acc_n  = step;
        digs_n = digs << 4;
        cnt_n  = cnt + {{(cnt_w-1){1'b0}}, 1'b1};
        if (!digit_ok(digit)) begin
          bad_n = 1'b1;
        end else begin
          bad_n = bad;
        end
        // Sticky bound keeps acc*10+15 inside the accumulator on the next step.
        if (step > half) begin
          ovf_n = 1'b1;
        end else begin
          ovf_n = ovf;
        end
        if (cnt == last) begin
          state_n = FIN;
        end else begin
          state_n = CONV;
        end
      end
      FIN: begin
        err_n = fault;
        if (fault) begin
          bin_n = {width{1'b0}};
        end else if (is_minus) begin
          bin_n = {width{1'b0}} - acc[width-1:0];
        end else begin
          bin_n = acc[width-1:0];
        end
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      digs  <= {(4*digits){1'b0}};
      sgn   <= 4'h0;
      acc   <= {acc_w{1'b0}};
      cnt   <= {cnt_w{1'b0}};
      ovf   <= 1'b0;
      bad   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= {width{1'b0}};
      err   <= 1'b0;
    end else begin
      state <= state_n;
      digs  <= digs_n;
      sgn   <= sgn_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
      bad   <= bad_n;
      busy  <= busy_n;
      done  <= done_n;
      bin   <= bin_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: cycle-by-cycle comparison against a
// countdown/arithmetic reference model, plus directed literal expectations.
module tb_bcd2bin;
  localparam int W = 6;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [4*D-1:0] bcd = '0;
  logic [3:0]     bcd_sgn = 4'hF;
  logic           busy, done, err;
  logic [W-1:0]   bin;

  int n_checks = 0;
  int n_pass   = 0;

  bcd2bin #(.width(W), .digits(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd), .bcd_sgn(bcd_sgn),
    .busy(busy), .done(done), .bin(bin), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: decimal value by plain arithmetic, then sign/range rules.
  function automatic logic [W:0] ref_conv(input logic [3:0] s, input logic [4*D-1:0] b);
    int mag = 0;
    int val;
    bit bad = 0;
    logic [3:0] d;
    for (int i = D - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 9) bad = 1;
      mag = mag * 10 + int'(d);
    end
    if (s != 4'hA && s != 4'hF) bad = 1;
    if (s == 4'hF && mag > (1 << (W - 1)) - 1) bad = 1;
    if (s == 4'hA && mag > (1 << (W - 1))) bad = 1;
    if (bad) return {1'b1, {W{1'b0}}};
    val = (s == 4'hA) ? -mag : mag;
    return {1'b0, W'(val)};
  endfunction

  // Timing model: a conversion ends D+1 edges after the accepted start.
  int           rem;
  logic         m_busy, m_done, m_err;
  logic [W-1:0] m_bin;
  logic [W:0]   pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_bin <= '0; m_err <= 1'b0; pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (rem == 0) begin
        if (start) begin
          rem <= D + 1; pend <= ref_conv(bcd_sgn, bcd); m_busy <= 1'b1;
        end
      end else begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done <= 1'b1; m_busy <= 1'b0; m_err <= pend[W]; m_bin <= pend[W-1:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("bin",  32'(bin),  32'(m_bin));
    check("err",  32'(err),  32'(m_err));
  end

  // Called just after a negedge; returns negedges until done (4 expected).
  task automatic go(input logic [3:0] s, input logic [7:0] b, output int lat);
    start = 1'b1; bcd_sgn = s; bcd = b;
    @(negedge clk);
    start = 1'b0; bcd = 8'($urandom); bcd_sgn = 4'($urandom);
    lat = 1;
    while (!done && lat < 12) begin @(negedge clk); lat++; end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic directed(input string name, input logic [3:0] s, input logic [7:0] b,
                          input logic [W-1:0] eb, input logic ee);
    int lat;
    go(s, b, lat);
    check({name, "_lat"}, 32'(lat), 32'd4);
    check({name, "_bin"}, 32'(bin), 32'(eb));
    check({name, "_err"}, 32'(err), 32'(ee));
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick_bcd();
    int v;
    case ($urandom_range(0, 3))
      0: return 8'($urandom);
      1: v = $urandom_range(0, 99);
      default: v = $urandom_range(28, 35);
    endcase
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    int lat;
    // Pin the reference model to hand-computed values.
    check("model_p31",  32'(ref_conv(4'hF, 8'h31)), 32'h1F);
    check("model_m32",  32'(ref_conv(4'hA, 8'h32)), 32'h20);
    check("model_m05",  32'(ref_conv(4'hA, 8'h05)), 32'h3B);
    check("model_p32",  32'(ref_conv(4'hF, 8'h32)), 32'h40);
    check("model_m00",  32'(ref_conv(4'hA, 8'h00)), 32'h00);
    check("model_sgn3", 32'(ref_conv(4'h3, 8'h10)), 32'h40);

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin",  32'(bin),  32'd0);
    check("rst_err",  32'(err),  32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    directed("pmax",   4'hF, 8'h31, 6'b011111, 1'b0);
    directed("nmin",   4'hA, 8'h32, 6'b100000, 1'b0);
    directed("nsmall", 4'hA, 8'h05, 6'b111011, 1'b0);
    directed("prange", 4'hF, 8'h32, 6'b000000, 1'b1);
    directed("nrange", 4'hA, 8'h99, 6'b000000, 1'b1);
    directed("baddig", 4'hF, 8'h1C, 6'b000000, 1'b1);
    directed("badsgn", 4'h3, 8'h10, 6'b000000, 1'b1);
    directed("mzero",  4'hA, 8'h00, 6'b000000, 1'b0);

    // start while busy is ignored
    start = 1'b1; bcd_sgn = 4'hF; bcd = 8'h12;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; bcd_sgn = 4'hA; bcd = 8'h05;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 10) begin @(negedge clk); lat++; end
    check("busy_ign_done", 32'(done), 32'd1);
    check("busy_ign_bin", 32'(bin), 32'h0C);
    check("busy_ign_err", 32'(err), 32'd0);
    // start in the done cycle
    go(4'hF, 8'h07, lat);
    check("b2b_lat", 32'(lat), 32'd4);
    check("b2b_bin", 32'(bin), 32'h07);
    @(negedge clk);

    // reset mid-conversion
    start = 1'b1; bcd_sgn = 4'hF; bcd = 8'h25;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bin",  32'(bin),  32'd0);
    check("midrst_err",  32'(err),  32'd0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_nodone", 32'(done), 32'd0);
    end
    directed("after_rst", 4'hF, 8'h07, 6'b000111, 1'b0);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      bcd = pick_bcd();
      case ($urandom_range(0, 7))
        0: bcd_sgn = 4'($urandom);
        1, 2, 3: bcd_sgn = 4'hA;
        default: bcd_sgn = 4'hF;
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
